// File: rtl/hazard_forward_unit_if.sv
// Decode-side bundle for the hazard/forwarding unit: instruction operands in, stall/forward/status out.
interface hazard_forward_unit_if #(
    parameter int RW        = 5,
    parameter int NUM_SRC   = 2,
    parameter int SW        = 2,
    parameter int CNT_WIDTH = 32
);
    logic                   id_valid;
    logic [NUM_SRC*RW-1:0]  id_src;
    logic [NUM_SRC-1:0]     id_src_used;
    logic [RW-1:0]          id_dst;
    logic                   id_reg_write;
    logic                   id_is_load;
    logic                   flush;
    logic                   halt;
    logic                   stall;
    logic [NUM_SRC*SW-1:0]  fwd_sel;
    logic [CNT_WIDTH-1:0]   stall_count;
    logic [CNT_WIDTH-1:0]   hazard_count;
    logic                   halted;

    modport master (
        output id_valid, id_src, id_src_used, id_dst, id_reg_write, id_is_load, flush, halt,
        input  stall, fwd_sel, stall_count, hazard_count, halted
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dst, id_reg_write, id_is_load, flush, halt,
        output stall, fwd_sel, stall_count, hazard_count, halted
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forward select for the MIPS-lite pipeline; MIPS_FORWARDING_EN enables bypassing.
// Latency: stall/fwd_sel are combinational from id_* and the scoreboard; counters and FSM update on the next edge.
// Backpressure: stall holds IF/ID and injects a bubble; without forwarding a reader waits until its producer retires.
module hazard_forward_unit #(
    parameter int REGISTERNUMBER = 32,
    parameter int NUM_SRC        = 2,
    parameter int FWD_STAGES     = 3,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    hazard_forward_unit_if.slave bus
);
    localparam int RW = $clog2(REGISTERNUMBER);
    localparam int SW = $clog2(FWD_STAGES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [SW-1:0]                  drain_cnt;
    logic [SW-1:0]                  drain_cnt_nxt;

    logic [FWD_STAGES-1:0]          sb_vld;
    logic [FWD_STAGES-1:0][RW-1:0]  sb_dst;

    logic                           run;
    logic                           gate;
    logic                           raw_stall;
    logic                           stall;
    logic                           accept;
    logic                           any_match;
    logic                           dep_seen;
    logic [NUM_SRC-1:0]             hit;
    logic [NUM_SRC*SW-1:0]          fwd_sel;
    logic [CNT_WIDTH-1:0]           stall_cnt;
    logic [CNT_WIDTH-1:0]           hazard_cnt;

`ifdef MIPS_FORWARDING_EN
    logic [FWD_STAGES-1:0]          sb_ld;
    logic [NUM_SRC-1:0][SW-1:0]     win;
`else
    logic                           unused_is_load;
    assign unused_is_load = bus.id_is_load;
`endif

    assign run       = (state == RUN);
    assign gate      = bus.id_valid & ~bus.flush & run;
    assign accept    = gate & ~raw_stall;
    assign any_match = |hit;

    // Scan oldest to youngest so the youngest matching stage is left as the winner.
    always_comb begin
        hit = '0;
`ifdef MIPS_FORWARDING_EN
        win = '0;
`endif
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = FWD_STAGES - 1; i >= 0; i--) begin
                if (sb_vld[i] && bus.id_src_used[k] &&
                    (sb_dst[i] == bus.id_src[k*RW +: RW]) &&
                    (bus.id_src[k*RW +: RW] != '0)) begin
                    hit[k] = 1'b1;
`ifdef MIPS_FORWARDING_EN
                    win[k] = SW'(i);
`endif
                end
            end
        end
    end

    always_comb begin
        raw_stall = 1'b0;
        fwd_sel   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef MIPS_FORWARDING_EN
            if (hit[k] && (win[k] == '0) && sb_ld[0]) raw_stall = 1'b1;
`else
            if (hit[k]) raw_stall = 1'b1;
`endif
        end
        stall = gate & raw_stall;
`ifdef MIPS_FORWARDING_EN
        for (int k = 0; k < NUM_SRC; k++) begin
            if (gate && !raw_stall && hit[k]) fwd_sel[k*SW +: SW] = win[k] + 1'b1;
        end
`endif
    end

    // Scoreboard shifts every clock; only accepted register writers occupy the EX slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_vld <= '0;
            sb_dst <= '0;
`ifdef MIPS_FORWARDING_EN
            sb_ld  <= '0;
`endif
        end else begin
            for (int i = FWD_STAGES - 1; i > 0; i--) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_dst[i] <= sb_dst[i-1];
`ifdef MIPS_FORWARDING_EN
                sb_ld[i]  <= sb_ld[i-1];
`endif
            end
            sb_vld[0] <= accept & bus.id_reg_write;
            sb_dst[0] <= bus.id_dst;
`ifdef MIPS_FORWARDING_EN
            sb_ld[0]  <= bus.id_is_load;
`endif
            if (state == HALTED) sb_vld <= '0;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (accept && bus.halt) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = SW'(FWD_STAGES);
                end
            end
            DRAIN: begin
                if (drain_cnt == SW'(1)) state_nxt = HALTED;
                else                     drain_cnt_nxt = drain_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            hazard_cnt <= '0;
            dep_seen   <= 1'b0;
        end else if (run) begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (accept && (any_match || dep_seen) && (hazard_cnt != '1))
                hazard_cnt <= hazard_cnt + 1'b1;
            if (bus.flush || accept) dep_seen <= 1'b0;
            else if (stall)          dep_seen <= 1'b1;
        end
    end

    assign bus.stall        = stall;
    assign bus.fwd_sel      = fwd_sel;
    assign bus.stall_count  = stall_cnt;
    assign bus.hazard_count = hazard_cnt;
    assign bus.halted       = (state == HALTED);
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: expectations queued by the driver, compared by a negedge monitor.
module tb_hazard_forward_unit;
    localparam int REGN = 32;
    localparam int NS   = 2;
    localparam int FS   = 3;
    localparam int CW   = 4;
    localparam int RW   = 5;
    localparam int SW   = 2;
`ifdef MIPS_FORWARDING_EN
    localparam int LU   = 2;
`else
    localparam int LU   = 4;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.RW(RW), .NUM_SRC(NS), .SW(SW), .CNT_WIDTH(CW)) bus ();

    hazard_forward_unit #(
        .REGISTERNUMBER(REGN), .NUM_SRC(NS), .FWD_STAGES(FS), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic [4:0] dst;
        logic       rw;
        logic       ld;
        logic       fl;
        logic       hl;
    } ins_t;

    typedef struct {
        string      name;
        logic       stall;
        logic [3:0] fwd;
        logic [3:0] sc;
        logic [3:0] hc;
        logic       halted;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    ins_t IDLE, ADD3, SUB5, LDW7, ADD8, ADD8F, ADD8H, ADD0, RD0, ADD10;

    function automatic ins_t mk(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                                input logic [4:0] dst, input logic rw, input logic ld);
        ins_t t;
        t.v = 1'b1; t.s0 = s0; t.s1 = s1; t.used = used; t.dst = dst;
        t.rw = rw; t.ld = ld; t.fl = 1'b0; t.hl = 1'b0;
        return t;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "stall",        {7'b0, bus.stall},        {7'b0, e.stall});
            cmp(e.name, "fwd_sel",      {4'b0, bus.fwd_sel},      {4'b0, e.fwd});
            cmp(e.name, "stall_count",  {4'b0, bus.stall_count},  {4'b0, e.sc});
            cmp(e.name, "hazard_count", {4'b0, bus.hazard_count}, {4'b0, e.hc});
            cmp(e.name, "halted",       {7'b0, bus.halted},       {7'b0, e.halted});
        end
    end

    task automatic drive(input logic rn, input ins_t t);
        reset_n          = rn;
        bus.id_valid     = t.v;
        bus.id_src       = {t.s1, t.s0};
        bus.id_src_used  = t.used;
        bus.id_dst       = t.dst;
        bus.id_reg_write = t.rw;
        bus.id_is_load   = t.ld;
        bus.flush        = t.fl;
        bus.halt         = t.hl;
    endtask

    task automatic cyc(input string nm, input logic rn, input ins_t t, input logic es,
                       input logic [3:0] ef, input int esc, input int ehc, input logic eh);
        exp_t e;
        drive(rn, t);
        e.name = nm; e.stall = es; e.fwd = ef; e.sc = esc[3:0]; e.hc = ehc[3:0]; e.halted = eh;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic run(input ins_t t);
        drive(1'b1, t);
        @(posedge clk); #1;
    endtask

    initial begin
        IDLE  = '0;
        ADD3  = mk(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
        SUB5  = mk(5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);
        LDW7  = mk(5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        ADD8  = mk(5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
        ADD0  = mk(5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0);
        RD0   = mk(5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0);
        ADD10 = mk(5'd1, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0);
        ADD8F = ADD8; ADD8F.fl = 1'b1;
        ADD8H = ADD8; ADD8H.hl = 1'b1;

        drive(1'b0, IDLE);
        repeat (2) @(posedge clk);
        #1;
        cyc("reset",       1'b0, IDLE, 0, 4'h0, 0, 0, 0);
        cyc("rst_release", 1'b1, IDLE, 0, 4'h0, 0, 0, 0);

        // Back-to-back ALU dependency, two writers of r3 in flight.
        cyc("a_add3",  1'b1, ADD3, 0, 4'h0, 0, 0, 0);
        cyc("a_add3b", 1'b1, ADD3, 0, 4'h0, 0, 0, 0);
`ifdef MIPS_FORWARDING_EN
        cyc("a_sub_fwd", 1'b1, SUB5, 0, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("a_idle", 1'b1, IDLE, 0, 4'h0, 0, 1, 0);
`else
        cyc("a_sub_st0", 1'b1, SUB5, 1, 4'h0, 0, 0, 0);
        cyc("a_sub_st1", 1'b1, SUB5, 1, 4'h0, 1, 0, 0);
        cyc("a_sub_st2", 1'b1, SUB5, 1, 4'h0, 2, 0, 0);
        cyc("a_sub_go",  1'b1, SUB5, 0, 4'h0, 3, 0, 0);
        for (int i = 0; i < 3; i++) cyc("a_idle", 1'b1, IDLE, 0, 4'h0, 3, 1, 0);
`endif

        // Load-use.
`ifdef MIPS_FORWARDING_EN
        cyc("b_ldw",   1'b1, LDW7, 0, 4'h0,    0, 1, 0);
        cyc("b_stall", 1'b1, ADD8, 1, 4'h0,    0, 1, 0);
        cyc("b_fwd",   1'b1, ADD8, 0, 4'b1010, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("b_idle", 1'b1, IDLE, 0, 4'h0, 1, 2, 0);
`else
        cyc("b_ldw",    1'b1, LDW7, 0, 4'h0, 3, 1, 0);
        cyc("b_stall0", 1'b1, ADD8, 1, 4'h0, 3, 1, 0);
        cyc("b_stall1", 1'b1, ADD8, 1, 4'h0, 4, 1, 0);
        cyc("b_stall2", 1'b1, ADD8, 1, 4'h0, 5, 1, 0);
        cyc("b_go",     1'b1, ADD8, 0, 4'h0, 6, 1, 0);
        for (int i = 0; i < 3; i++) cyc("b_idle", 1'b1, IDLE, 0, 4'h0, 6, 2, 0);
`endif

        // r0 never matches; flush during a stall squashes without counting.
`ifdef MIPS_FORWARDING_EN
        cyc("c_add_r0", 1'b1, ADD0,  0, 4'h0, 1, 2, 0);
        cyc("c_rd_r0",  1'b1, RD0,   0, 4'h0, 1, 2, 0);
        cyc("c_ldw",    1'b1, LDW7,  0, 4'h0, 1, 2, 0);
        cyc("c_stall",  1'b1, ADD8,  1, 4'h0, 1, 2, 0);
        cyc("c_flush",  1'b1, ADD8F, 0, 4'h0, 2, 2, 0);
        cyc("c_indep",  1'b1, ADD10, 0, 4'h0, 2, 2, 0);
        for (int i = 0; i < 3; i++) cyc("c_idle", 1'b1, IDLE, 0, 4'h0, 2, 2, 0);
        cyc("r_ldw",    1'b1, LDW7,  0, 4'h0, 2, 2, 0);
        cyc("r_stall",  1'b1, ADD8,  1, 4'h0, 2, 2, 0);
`else
        cyc("c_add_r0", 1'b1, ADD0,  0, 4'h0, 6, 2, 0);
        cyc("c_rd_r0",  1'b1, RD0,   0, 4'h0, 6, 2, 0);
        cyc("c_ldw",    1'b1, LDW7,  0, 4'h0, 6, 2, 0);
        cyc("c_stall",  1'b1, ADD8,  1, 4'h0, 6, 2, 0);
        cyc("c_flush",  1'b1, ADD8F, 0, 4'h0, 7, 2, 0);
        cyc("c_indep",  1'b1, ADD10, 0, 4'h0, 7, 2, 0);
        for (int i = 0; i < 3; i++) cyc("c_idle", 1'b1, IDLE, 0, 4'h0, 7, 2, 0);
        cyc("r_ldw",    1'b1, LDW7,  0, 4'h0, 7, 2, 0);
        cyc("r_stall",  1'b1, ADD8,  1, 4'h0, 7, 2, 0);
`endif
        // Reset lands mid-cycle while the stall is active; checked before the next edge.
        cyc("r_async",   1'b0, ADD8, 0, 4'h0, 0, 0, 0);
        cyc("r_release", 1'b1, IDLE, 0, 4'h0, 0, 0, 0);

        // Halt presented while stalled is held off, then drains to HALTED.
`ifdef MIPS_FORWARDING_EN
        cyc("h_ldw",   1'b1, LDW7,  0, 4'h0,    0, 0, 0);
        cyc("h_stall", 1'b1, ADD8H, 1, 4'h0,    0, 0, 0);
        cyc("h_go",    1'b1, ADD8H, 0, 4'b1010, 1, 0, 0);
        cyc("h_d0",    1'b1, LDW7,  0, 4'h0,    1, 1, 0);
        cyc("h_d1",    1'b1, ADD8,  0, 4'h0,    1, 1, 0);
        cyc("h_d2",    1'b1, ADD8,  0, 4'h0,    1, 1, 0);
        cyc("h_halt",  1'b1, ADD8,  0, 4'h0,    1, 1, 1);
        cyc("h_halt2", 1'b1, ADD8,  0, 4'h0,    1, 1, 1);
`else
        cyc("h_ldw",    1'b1, LDW7,  0, 4'h0, 0, 0, 0);
        cyc("h_stall0", 1'b1, ADD8H, 1, 4'h0, 0, 0, 0);
        cyc("h_stall1", 1'b1, ADD8H, 1, 4'h0, 1, 0, 0);
        cyc("h_stall2", 1'b1, ADD8H, 1, 4'h0, 2, 0, 0);
        cyc("h_go",     1'b1, ADD8H, 0, 4'h0, 3, 0, 0);
        cyc("h_d0",     1'b1, LDW7,  0, 4'h0, 3, 1, 0);
        cyc("h_d1",     1'b1, ADD8,  0, 4'h0, 3, 1, 0);
        cyc("h_d2",     1'b1, ADD8,  0, 4'h0, 3, 1, 0);
        cyc("h_halt",   1'b1, ADD8,  0, 4'h0, 3, 1, 1);
        cyc("h_halt2",  1'b1, ADD8,  0, 4'h0, 3, 1, 1);
`endif
        cyc("rst2",     1'b0, IDLE, 0, 4'h0, 0, 0, 0);
        cyc("rst2_rel", 1'b1, IDLE, 0, 4'h0, 0, 0, 0);

        // Drive both counters past all-ones with repeated load-use pairs.
        for (int n = 0; n < 16; n++) begin
            run(LDW7);
            for (int j = 0; j < LU; j++) run(ADD8);
        end
        cyc("s_sat",  1'b1, IDLE, 0, 4'h0, 15, 15, 0);
        cyc("s_ldw",  1'b1, LDW7, 0, 4'h0, 15, 15, 0);
`ifdef MIPS_FORWARDING_EN
        cyc("s_stall", 1'b1, ADD8, 1, 4'h0,    15, 15, 0);
        cyc("s_fwd",   1'b1, ADD8, 0, 4'b1010, 15, 15, 0);
`else
        for (int j = 0; j < 3; j++) cyc("s_stall", 1'b1, ADD8, 1, 4'h0, 15, 15, 0);
        cyc("s_go",    1'b1, ADD8, 0, 4'h0, 15, 15, 0);
`endif
        cyc("s_idle", 1'b1, IDLE, 0, 4'h0, 15, 15, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the 5-stage MIPS-lite pipeline.
- Replaces the per-buffer forward1/2, memForward1/2 and wbForward1/2 flags with one unit.
- Tracks in-flight destination registers in an internal scoreboard shift register.
- Drives stall and per-source forward selects to decode, and maintains saturating stall and data-hazard counters.

Parameters:
- REGISTERNUMBER, 32, architectural register count; RW = $clog2(REGISTERNUMBER).
- NUM_SRC, 2, source operands checked per instruction.
- FWD_STAGES, 3, tracked in-flight stages after decode (index 0 = EX, 1 = MEM, 2 = WB); SW = $clog2(FWD_STAGES+1).
- CNT_WIDTH, 32, counter width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_src  in  NUM_SRC*RW  source register indices; src k is at bits [k*RW +: RW].
- id_src_used  in  NUM_SRC  source k is actually read.
- id_dst  in  RW  destination register.
- id_reg_write  in  1  instruction writes id_dst.
- id_is_load  in  1  instruction is a load.
- flush  in  1  branch taken; squash the decode instruction.
- halt  in  1  HALT decoded.
- stall  out  SW-independent 1  hold IF/ID and insert a bubble into EX.
- fwd_sel  out  NUM_SRC*SW  per source: 0 = regfile, i+1 = stage i.
- stall_count  out  CNT_WIDTH  stall cycles.
- hazard_count  out  CNT_WIDTH  instructions that had at least one RAW dependency.
- halted  out  1  unit is in HALTED.

Behaviour:
- Reset (async, reset_n=0):
  - Scoreboard entries invalid; state RUN.
  - Counters, dep_seen and halted all 0.
  - stall=0 and fwd_sel=0 follow combinationally from the empty scoreboard.
- Scoreboard:
  - FWD_STAGES entries {valid, dst, is_load}, shifted every clock (i → i+1; the oldest entry drops).
  - Entry 0 loads {id_valid & id_reg_write & ~stall & ~flush & (state==RUN), id_dst, id_is_load}; otherwise it loads a bubble (valid=0).
- Match rule: source k matches stage i if entry i is valid, dst == id_src[k], id_src_used[k]=1, and id_src[k] != 0. Register 0 never matches.
- Priority: the youngest (lowest index) matching stage wins.
- Load-use: the winning match is stage 0 with is_load=1 → stall=1 for that cycle.
  - Next cycle the load sits in stage 1, so the match forwards from MEM (fwd_sel=2); the stall lasts exactly 1 cycle.
- fwd_sel[k]: winner index+1 when matched and not stalled, else 0. Combinational, same cycle as the id_* inputs.
- Gating: stall and fwd_sel are forced to 0 when id_valid=0, flush=1, or state != RUN. Flush dominates stall.
- hazard_count:
  - Sticky dep_seen is set on any stall cycle.
  - Increment when an instruction is accepted (id_valid & ~stall & ~flush in RUN) and (any source matched OR dep_seen). dep_seen clears on that acceptance.
  - Flush also clears dep_seen without counting.
- stall_count: increments every cycle stall=1.
- Both counters saturate at all-ones and are frozen outside RUN.
- State machine:
  - RUN → DRAIN when halt & id_valid & ~flush & ~stall (the halt instruction itself is accepted).
  - DRAIN: down-counter loaded with FWD_STAGES; only bubbles are inserted; leaves for HALTED when the counter reaches 1.
  - HALTED: halted=1; scoreboard all invalid; exits only via reset.
- halt while stall=1 is ignored until the stall clears.

Optional Feature:
- Macro: MIPS_FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - No forwarding; fwd_sel tied to 0.
  - Any source match in any valid stage → stall=1 until the producer leaves the scoreboard, independent of is_load.
  - Counters and FSM are unchanged.

Test Plan:
- Reset: reset_n=0 mid-stream with stall active → stall=0, fwd_sel=0, counters=0, halted=0 asynchronously, before the next edge.
- ADD r3 then SUB r5,r3,r4 back-to-back (forwarding on) → fwd_sel[0]=1, stall=0, hazard_count=1, stall_count=0.
- LDW r7 then ADD r8,r7,r7 → 1 stall cycle, then fwd_sel = {2,2}; stall_count=1, hazard_count=1.
- Same load-use sequence with MIPS_FORWARDING_EN undefined → stall for 3 cycles, fwd_sel=0 throughout, stall_count=3, hazard_count=1.
- ADD r0,… followed by a reader of r0, and flush asserted during a stall → no match on r0; flush forces stall=0 and the squashed instruction is not counted.
- HALT accepted → halted=1 after FWD_STAGES+1 clocks; later stimulus leaves stall_count and hazard_count unchanged. Preset a counter to all-ones → it stays all-ones (saturation).
